// File: rtl/score_reader.sv
// Score playback sequencer: fetches score entries from memory and sequences each note/rest with a gap.
// Optional SCORE_READER_LOOP_EN macro wraps playback back to entry 0 instead of finishing.
module score_reader #(
    parameter int unsigned BEAT_DIV = 12500000,
    parameter int unsigned GAP_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] mem_len,
    output logic       mem_rd,
    output logic [5:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [2:0] value_out,
    output logic [1:0] tone_out,
    output logic       note_strobe,
    output logic       busy,
    output logic       done
);

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned LEN_W    = 7;
    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned HOLD_MAX = 8 * BEAT_DIV;
    localparam int unsigned CNT_MAX  = (HOLD_MAX > GAP_CYC) ? HOLD_MAX : GAP_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         value_q, value_d;
    logic [1:0]         tone_q, tone_d;
    logic               strobe_q, strobe_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  maddr_q, maddr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   eff_len_c;
    logic [LEN_W-1:0]   addr_inc_c;
    logic [CNT_W-1:0]   hold_cnt_c;
    logic               advance_c;

    always_comb begin
        eff_len_c  = (mem_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : mem_len;
        addr_inc_c = addr_q + LEN_W'(1);
        // Beat counter preload: (dur+1) beats, counted down to zero.
        hold_cnt_c = CNT_W'(BEAT_DIV) * (CNT_W'(mem_data[2:0]) + CNT_W'(1)) - CNT_W'(1);
    end

    // Next-state and registered-output decisions.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        tone_d    = tone_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        advance_c = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            value_d = 3'd0;
            tone_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        len_d   = eff_len_c;
                        state_d = (eff_len_c == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    value_d  = mem_data[7:5];
                    tone_d   = mem_data[4:3];
                    strobe_d = 1'b1;
                    cnt_d    = hold_cnt_c;
                    state_d  = S_HOLD;
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        value_d = 3'd0;
                        if (GAP_CYC == 0) begin
                            advance_c = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(GAP_CYC - 1);
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        advance_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (advance_c) begin
                if (addr_inc_c < len_q) begin
                    addr_d  = addr_inc_c;
                    state_d = S_FETCH;
                end else begin
`ifdef SCORE_READER_LOOP_EN
                    addr_d  = '0;
                    state_d = S_FETCH;
`else
                    state_d = S_DONE;
`endif
                end
            end
        end

        rd_d    = (state_d == S_FETCH);
        maddr_d = (state_d == S_FETCH) ? addr_d[ADDR_W-1:0] : '0;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            value_q  <= 3'd0;
            tone_q   <= 2'd0;
            strobe_q <= 1'b0;
            rd_q     <= 1'b0;
            maddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            tone_q   <= tone_d;
            strobe_q <= strobe_d;
            rd_q     <= rd_d;
            maddr_q  <= maddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign value_out   = value_q;
    assign tone_out    = tone_q;
    assign note_strobe = strobe_q;
    assign mem_rd      = rd_q;
    assign mem_addr    = maddr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_score_reader.sv
// Bench for score_reader: a cycle-by-cycle expected trace is built from the score contents and compared.
// Honors SCORE_READER_LOOP_EN the same way as the design.
module tb_score_reader;

    localparam int unsigned BD = 4;
    localparam int unsigned GC = 2;
`ifdef SCORE_READER_LOOP_EN
    localparam int PASSES = 3;
    localparam bit LOOP   = 1'b1;
`else
    localparam int PASSES = 1;
    localparam bit LOOP   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [6:0] mem_len;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic [2:0] value_out;
    logic [1:0] tone_out;
    logic       note_strobe;
    logic       busy;
    logic       done;

    score_reader #(.BEAT_DIV(BD), .GAP_CYC(GC)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mem_len(mem_len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .value_out(value_out), .tone_out(tone_out), .note_strobe(note_strobe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] v;
        logic [1:0] t;
        logic       s;
        logic       b;
        logic       d;
        logic       r;
        logic [5:0] a;
    } obs_t;

    logic [7:0] mem [64];
    obs_t       exp_q [$];
    logic [2:0] cur_v;
    logic [1:0] cur_t;
    int         vectors = 0;
    int         miscompares = 0;

    // Score memory: data returned the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    function automatic obs_t mk(logic [2:0] v, logic [1:0] t, logic s, logic b,
                                logic d, logic r, logic [5:0] a);
        obs_t o;
        o = '{v: v, t: t, s: s, b: b, d: d, r: r, a: a};
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(value_out, tone_out, note_strobe, busy, done, mem_rd, mem_addr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got v=%0d t=%0d s=%0b b=%0b d=%0b rd=%0b a=%0d exp v=%0d t=%0d s=%0b b=%0b d=%0b rd=%0b a=%0d",
                   tag, got.v, got.t, got.s, got.b, got.d, got.r, got.a,
                   exp.v, exp.t, exp.s, exp.b, exp.d, exp.r, exp.a);
        end
    endtask

    // Expected per-cycle trace of one playback, starting with the cycle after start is sampled.
    task automatic build(input int len);
        int eff;
        logic [2:0] v;
        logic [1:0] t;
        int dur;
        eff = (len > 64) ? 64 : len;
        if (eff == 0) begin
            exp_q.push_back(mk(cur_v, cur_t, 0, 1, 0, 0, 0));
            exp_q.push_back(mk(cur_v, cur_t, 0, 0, 1, 0, 0));
            return;
        end
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < eff; i++) begin
                exp_q.push_back(mk(cur_v, cur_t, 0, 1, 0, 1, 6'(i)));
                exp_q.push_back(mk(cur_v, cur_t, 0, 1, 0, 0, 0));
                v   = mem[i][7:5];
                t   = mem[i][4:3];
                dur = (int'(mem[i][2:0]) + 1) * BD;
                for (int k = 0; k < dur; k++) exp_q.push_back(mk(v, t, k == 0, 1, 0, 0, 0));
                cur_v = 3'd0;
                cur_t = t;
                for (int g = 0; g < GC; g++) exp_q.push_back(mk(0, t, 0, 1, 0, 0, 0));
            end
        end
        if (!LOOP) begin
            exp_q.push_back(mk(cur_v, cur_t, 0, 1, 0, 0, 0));
            exp_q.push_back(mk(cur_v, cur_t, 0, 0, 1, 0, 0));
        end
    endtask

    // Launch a playback and check up to n cycles of the trace (n < 0: all of it).
    task automatic play(input string tag, input int len, input bit hold, input int n);
        int cnt;
        exp_q.delete();
        build(len);
        mem_len = 7'(len);
        start   = 1'b1;
        cnt     = 0;
        while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
            step();
            if (!hold) start = 1'b0;
            check(tag, sample(), exp_q.pop_front());
            cnt++;
        end
    endtask

    // In loop builds playback never ends on its own, so abort it to reach idle.
    task automatic quiesce();
        if (LOOP) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            check("loop_stop", sample(), mk(0, 0, 0, 0, 0, 0, 0));
            cur_v = 3'd0;
            cur_t = 2'd0;
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, sample(), mk(cur_v, cur_t, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mem_len = 7'd0;
        cur_v   = 3'd0;
        cur_t   = 2'd0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        repeat (2) step();
        check("reset", sample(), mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        idle_check("idle_after_reset", 2);

        // Two-entry directed score: 1/tone0 for 3 beats, 7/tone1 for 2 beats.
        mem[0] = 8'h22;
        mem[1] = 8'hE9;
        play("two_note", 2, 1'b0, -1);
        quiesce();
        idle_check("idle_after_two", 2);

        // Empty score finishes without reading memory.
        play("empty", 0, 1'b0, -1);
        idle_check("idle_after_empty", 2);

        // Stop wins over a simultaneous start.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("stop_vs_start", sample(), mk(cur_v, 0, 0, 0, 0, 0, 0));
        cur_t = 2'd0;

        // Stop during the fifth HOLD cycle, then restart from address 0.
        mem[0] = 8'b101_10_011;
        mem[1] = 8'(($urandom() & 32'hFF));
        mem[2] = 8'(($urandom() & 32'hFF));
        play("pre_stop", 3, 1'b0, 7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_hold", sample(), mk(0, 0, 0, 0, 0, 0, 0));
        exp_q.delete();
        cur_v = 3'd0;
        cur_t = 2'd0;
        idle_check("idle_after_stop", 3);
        play("restart", 3, 1'b0, -1);
        quiesce();

`ifndef SCORE_READER_LOOP_EN
        // Start held through playback: one playback, next begins right after done.
        mem[0] = 8'b011_01_000;
        mem[1] = 8'b000_11_001;
        play("held_start", 2, 1'b1, -1);
        step();
        check("held_restart", sample(), mk(cur_v, cur_t, 0, 1, 0, 1, 0));
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop  = 1'b0;
        check("held_abort", sample(), mk(0, 0, 0, 0, 0, 0, 0));
        cur_v = 3'd0;
        cur_t = 2'd0;
`else
        // Single-entry loop: entry repeats from address 0 with no done pulse.
        mem[0] = 8'b100_10_010;
        play("loop_one", 1, 1'b0, -1);
        quiesce();
`endif

        // Asynchronous reset mid-HOLD silences outputs without a clock edge.
        mem[0] = 8'b110_11_010;
        play("pre_rst", 1, 1'b0, 5);
        #3 rst = 1'b0;
        #1 check("async_rst", sample(), mk(0, 0, 0, 0, 0, 0, 0));
        #2 rst = 1'b1;
        exp_q.delete();
        cur_v = 3'd0;
        cur_t = 2'd0;
        idle_check("idle_after_rst", 2);

        // Random scores, including one whose length is clamped to 64.
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
            play("random", (n == 4) ? 127 : int'($urandom_range(1, 6)), 1'b0, -1);
            quiesce();
            idle_check("idle_after_random", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_reader.md
SCORE_READER -- requirements
Module: score_reader

Interface
REQ-001 SHALL have parameter BEAT_DIV, default 12500000, clk cycles per beat (0.25 s at 50 MHz).
REQ-002 SHALL have parameter GAP_CYC, default 1000000, silent cycles inserted after every entry.
REQ-003 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level-sampled playback request.
REQ-006 SHALL have port stop  input  1  abort playback.
REQ-007 SHALL have port mem_len  input  7  number of valid score entries, 0..64.
REQ-008 SHALL have port mem_rd  output  1  score memory read strobe.
REQ-009 SHALL have port mem_addr  output  6  score memory entry address.
REQ-010 SHALL have port mem_data  input  8  entry returned one cycle after mem_rd: [7:5] value, [4:3] tone, [2:0] dur.
REQ-011 SHALL have port value_out  output  3  note value 1..7, 0 = silent.
REQ-012 SHALL have port tone_out  output  2  octave code, same encoding as the keyboard tone input.
REQ-013 SHALL have port note_strobe  output  1  one-cycle pulse when a new entry appears on value_out/tone_out.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at normal end of score.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, HOLD, GAP, DONE.
REQ-017 SHALL, in IDLE with start=1 and stop=0, clear the address counter and go to FETCH, or to DONE if mem_len=0.
REQ-018 SHALL drive mem_rd=1 and mem_addr=address counter only in FETCH, then go to WAIT.
REQ-019 SHALL, at the end of WAIT, register mem_data[7:5] to value_out and [4:3] to tone_out, pulse note_strobe in the first HOLD cycle, and load the beat counter.
REQ-020 SHALL stay in HOLD exactly (dur+1)*BEAT_DIV cycles, covering durations of 1..8 beats.
REQ-021 SHALL treat an entry with value=0 as a rest: same timing, value_out=0.
REQ-022 SHALL, in GAP, force value_out=0 and tone_out unchanged for GAP_CYC cycles, then increment the address.
REQ-023 SHALL go from GAP to FETCH if the incremented address is below the effective length, otherwise to DONE.
REQ-024 SHALL clamp an effective length greater than 64 to 64, and SHALL latch the effective length at start.
REQ-025 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-026 SHALL, when stop=1 in any state, go to IDLE on the next edge with value_out=0, tone_out=0 and no done pulse; stop SHALL win over a simultaneous start.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL give 3 cycles of latency from start sampled to the note_strobe cycle (IDLE, then FETCH, then WAIT).

Reset
REQ-029 SHALL, while rst=0, force the state to IDLE and all counters to 0.
REQ-030 SHALL, while rst=0, drive value_out=0, tone_out=0, mem_rd=0, mem_addr=0, note_strobe=0, busy=0 and done=0.
REQ-031 SHALL, when rst is asserted mid-note, silence the output immediately without waiting for a clock edge.

Configuration
REQ-032 SHALL, with SCORE_READER_LOOP_EN defined, wrap the address from the last entry back to 0 and go GAP to FETCH, with no done pulse; playback SHALL end only by stop or reset.
REQ-033 SHALL, without SCORE_READER_LOOP_EN, play the score once and finish as described in REQ-023 and REQ-025.

Verification (BEAT_DIV=4, GAP_CYC=2)
REQ-034 SHALL cover: mem_len=2, entries 8'h22 and 8'hE9, start pulse -> value_out 1 for 12 cycles, 0 for 2, 7 (tone 01) for 8, 0 for 2, then done pulse and busy=0.
REQ-035 SHALL cover: mem_len=0, start -> done pulse 2 cycles after start, mem_rd never asserted.
REQ-036 SHALL cover: stop asserted in cycle 5 of HOLD -> next cycle IDLE, value_out=0, no done pulse; a second start restarts at address 0.
REQ-037 SHALL cover: start held high through playback -> exactly one playback, and a new playback begins the cycle after done.
REQ-038 SHALL cover: rst driven low mid-HOLD -> value_out=0 and busy=0 asynchronously; with SCORE_READER_LOOP_EN, mem_len=1 -> address stays 0, note_strobe repeats every 4*(dur+1)+2+2 cycles, done never pulses.
